// File: rtl/stage4_mem_pkg.sv
// Shared types and widths for the memory-access pipeline stage.
package stage4_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned REG_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              RegWrite;
        logic [REG_W-1:0]  D;
        logic [DATA_W-1:0] data;
    } wb_bundle_t;

endpackage

// File: rtl/stage4_mem_timeout_ctr.sv
// Cycle counter bounding how long an access may wait for mem_ack.
module mem_timeout_ctr #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Clear takes priority; otherwise count each enabled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/stage4_mem.sv
// Memory-access stage: issues loads/stores over req/ack, stalls upstream
// while an access is outstanding, aborts on timeout, registers writeback.
module stage4_mem
    import stage4_mem_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] ALU_Result,
    input  logic [REG_W-1:0]  D,
    input  logic [ADDR_W-1:0] address,
    input  logic              RegWrite,
    input  logic              RegInsrc,
    input  logic              DataRead,
    input  logic              DataWrite,
    input  logic              JumpSrc,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic [REG_W-1:0]  wb_D,
    output logic [DATA_W-1:0] wb_data,
    output logic              jump_taken,
    output logic [ADDR_W-1:0] jump_addr,
    output logic              mem_err
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    wb_bundle_t        wb_q, wb_d;
    logic              jump_taken_q, jump_taken_d;
    logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
    logic              mem_err_q, mem_err_d;
    // Latched controls; ALU_Result and address live on in mem_wdata_q / mem_addr_q.
    logic              lat_rw_q, lat_rw_d;
    logic              lat_insrc_q, lat_insrc_d;
    logic              lat_js_q, lat_js_d;
    logic [REG_W-1:0]  lat_d_q, lat_d_d;

    logic mem_op;
    logic tc;

    assign mem_op = in_valid & (DataRead | DataWrite);

    mem_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == IDLE),
        .en_i  ((state_q == BUSY) & ~mem_ack),
        .tc_o  (tc)
    );

    // Upstream stall; released in the ack or abort cycle, and forced low in reset.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            if (state_q == IDLE) begin
                stall = mem_op;
            end else begin
                stall = ~mem_ack & ~tc;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wb_d         = wb_q;
        wb_d.valid   = 1'b0;
        wb_d.RegWrite = 1'b0;
        jump_taken_d = 1'b0;
        jump_addr_d  = jump_addr_q;
        mem_err_d    = mem_err_q;
        lat_rw_d     = lat_rw_q;
        lat_insrc_d  = lat_insrc_q;
        lat_js_d     = lat_js_q;
        lat_d_d      = lat_d_q;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = DataWrite;
                    mem_addr_d  = address;
                    mem_wdata_d = ALU_Result;
                    lat_rw_d    = RegWrite;
                    lat_insrc_d = RegInsrc;
                    lat_js_d    = JumpSrc;
                    lat_d_d     = D;
                end else begin
                    wb_d.valid    = in_valid;
                    wb_d.RegWrite = in_valid & RegWrite;
                    wb_d.D        = D;
                    wb_d.data     = ALU_Result;
                    jump_taken_d  = in_valid & JumpSrc;
                    jump_addr_d   = address;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    wb_d.valid    = 1'b1;
                    wb_d.RegWrite = lat_rw_q;
                    wb_d.D        = lat_d_q;
                    wb_d.data     = (lat_insrc_q & ~mem_we_q) ? mem_rdata : mem_wdata_q;
                    jump_taken_d  = lat_js_q;
                    jump_addr_d   = mem_addr_q;
                end else if (tc) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    mem_err_d     = 1'b1;
                    wb_d.valid    = 1'b1;
                    wb_d.D        = lat_d_q;
                    wb_d.data     = mem_wdata_q;
                    jump_addr_d   = mem_addr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wb_q         <= '0;
            jump_taken_q <= 1'b0;
            jump_addr_q  <= '0;
            mem_err_q    <= 1'b0;
            lat_rw_q     <= 1'b0;
            lat_insrc_q  <= 1'b0;
            lat_js_q     <= 1'b0;
            lat_d_q      <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_q         <= wb_d;
            jump_taken_q <= jump_taken_d;
            jump_addr_q  <= jump_addr_d;
            mem_err_q    <= mem_err_d;
            lat_rw_q     <= lat_rw_d;
            lat_insrc_q  <= lat_insrc_d;
            lat_js_q     <= lat_js_d;
            lat_d_q      <= lat_d_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = wb_q.valid;
    assign wb_RegWrite = wb_q.RegWrite;
    assign wb_D        = wb_q.D;
    assign wb_data     = wb_q.data;
    assign jump_taken  = jump_taken_q;
    assign jump_addr   = jump_addr_q;
    assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_stage4_mem.sv
// Directed bench for stage4_mem: vector table for pass-through ops plus
// hand-written load/store/timeout/reset sequences.
module tb_stage4_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] ALU_Result;
    logic [3:0]  D;
    logic [7:0]  address;
    logic        RegWrite, RegInsrc, DataRead, DataWrite, JumpSrc;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        wb_valid, wb_RegWrite, jump_taken, mem_err;
    logic [3:0]  wb_D;
    logic [31:0] wb_data;
    logic [7:0]  jump_addr;

    int n_checks = 0;
    int n_fail   = 0;

    stage4_mem #(
        .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALU_Result(ALU_Result),
        .D(D), .address(address), .RegWrite(RegWrite), .RegInsrc(RegInsrc),
        .DataRead(DataRead), .DataWrite(DataWrite), .JumpSrc(JumpSrc),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_D(wb_D),
        .wb_data(wb_data), .jump_taken(jump_taken), .jump_addr(jump_addr),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] alu;
        logic [3:0]  d;
        logic [7:0]  addr;
        logic        rw;
        logic        js;
        logic        ack;
        logic        e_wv;
        logic        e_rw;
        logic [3:0]  e_d;
        logic [31:0] e_data;
        logic        e_jt;
        logic [7:0]  e_ja;
    } vec_t;

    vec_t tv[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] alu, input logic [3:0] d,
                         input logic [7:0] addr, input logic rw, input logic insrc,
                         input logic dr, input logic dw, input logic js);
        in_valid   = iv;
        ALU_Result = alu;
        D          = d;
        address    = addr;
        RegWrite   = rw;
        RegInsrc   = insrc;
        DataRead   = dr;
        DataWrite  = dw;
        JumpSrc    = js;
    endtask

    initial begin
        tv[0] = '{1'b1, 32'h1234_5678, 4'd3,  8'h00, 1'b1, 1'b0, 1'b0,
                  1'b1, 1'b1, 4'd3,  32'h1234_5678, 1'b0, 8'h00};
        tv[1] = '{1'b1, 32'hCAFE_F00D, 4'd9,  8'h40, 1'b0, 1'b1, 1'b1,
                  1'b1, 1'b0, 4'd9,  32'hCAFE_F00D, 1'b1, 8'h40};
        tv[2] = '{1'b0, 32'h0BAD_F00D, 4'd7,  8'h11, 1'b1, 1'b1, 1'b0,
                  1'b0, 1'b0, 4'd7,  32'h0BAD_F00D, 1'b0, 8'h11};
        tv[3] = '{1'b1, 32'hFFFF_FFFF, 4'd15, 8'hFF, 1'b1, 1'b1, 1'b0,
                  1'b1, 1'b1, 4'd15, 32'hFFFF_FFFF, 1'b1, 8'hFF};

        rst_n = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;
        step();

        // Non-memory ops, one-cycle latency, stall never asserted
        for (int i = 0; i < 4; i++) begin
            drive(tv[i].iv, tv[i].alu, tv[i].d, tv[i].addr, tv[i].rw, 1'b0, 1'b0, 1'b0, tv[i].js);
            mem_ack = tv[i].ack;
            #1;
            chk("tbl_stall", stall, 0);
            step();
            chk("tbl_wb_valid", wb_valid, tv[i].e_wv);
            chk("tbl_wb_regwrite", wb_RegWrite, tv[i].e_rw);
            chk("tbl_wb_d", wb_D, tv[i].e_d);
            chk("tbl_wb_data", wb_data, tv[i].e_data);
            chk("tbl_jump_taken", jump_taken, tv[i].e_jt);
            chk("tbl_jump_addr", jump_addr, tv[i].e_ja);
            chk("tbl_mem_req", mem_req, 0);
        end
        mem_ack = 1'b0;

        // Load, ack on third request cycle
        drive(1'b1, 32'h1111_1111, 4'd5, 8'h2A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("ld_stall_n", stall, 1);
        step();
        for (int i = 1; i <= 3; i++) begin
            chk("ld_mem_req", mem_req, 1);
            chk("ld_mem_we", mem_we, 0);
            chk("ld_mem_addr", mem_addr, 32'h2A);
            chk("ld_wb_valid_busy", wb_valid, 0);
            if (i == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            chk("ld_stall", stall, (i == 3) ? 0 : 1);
            step();
        end
        mem_ack = 1'b0;
        in_valid = 1'b0;
        chk("ld_req_drop", mem_req, 0);
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_regwrite", wb_RegWrite, 1);
        chk("ld_wb_d", wb_D, 5);
        chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
        step();

        // Store with both DataRead and DataWrite; rdata must be ignored
        drive(1'b1, 32'hA5A5_0000, 4'd2, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("st_mem_req", mem_req, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_wdata", mem_wdata, 32'hA5A5_0000);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("st_stall_ack", stall, 0);
        step();
        mem_ack = 1'b0;
        in_valid = 1'b0;
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_data", wb_data, 32'hA5A5_0000);
        chk("st_wb_regwrite", wb_RegWrite, 0);
        step();

        // Ack coincident with terminal count: normal writeback, no error
        drive(1'b1, 32'h0000_0001, 4'd6, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        for (int i = 1; i <= 4; i++) begin
            chk("tca_mem_req", mem_req, 1);
            if (i == 4) begin
                mem_ack = 1'b1;
                mem_rdata = 32'h600D_0004;
            end
            step();
        end
        mem_ack = 1'b0;
        in_valid = 1'b0;
        chk("tca_mem_req_drop", mem_req, 0);
        chk("tca_mem_err", mem_err, 0);
        chk("tca_wb_valid", wb_valid, 1);
        chk("tca_wb_regwrite", wb_RegWrite, 1);
        chk("tca_wb_data", wb_data, 32'h600D_0004);
        chk("tca_jump_taken", jump_taken, 1);
        chk("tca_jump_addr", jump_addr, 32'h55);
        step();

        // Timeout: request held exactly 4 cycles, then abort
        drive(1'b1, 32'h7777_0000, 4'd8, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        for (int i = 1; i <= 4; i++) begin
            chk("to_mem_req", mem_req, 1);
            chk("to_stall", stall, (i == 4) ? 0 : 1);
            step();
        end
        in_valid = 1'b0;
        chk("to_mem_req_drop", mem_req, 0);
        chk("to_mem_err", mem_err, 1);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_regwrite", wb_RegWrite, 0);
        chk("to_jump_taken", jump_taken, 0);
        step();

        // Sticky error across a later op
        drive(1'b1, 32'h0000_00AA, 4'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("sticky_mem_err", mem_err, 1);
        chk("sticky_wb_data", wb_data, 32'h0000_00AA);

        // Reset asserted mid-access, no clock edge
        drive(1'b1, 32'h4444_4444, 4'd4, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("mid_mem_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_stall", stall, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_wb_data", wb_data, 0);
        chk("arst_mem_err", mem_err, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        step();

        // First op after reset: load with earliest ack, RegInsrc=0 keeps ALU value
        drive(1'b1, 32'h1357_9BDF, 4'd10, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("post_mem_req", mem_req, 1);
        chk("post_mem_addr", mem_addr, 32'h33);
        mem_ack = 1'b1;
        mem_rdata = 32'h0F0F_0F0F;
        #1;
        chk("post_stall_ack", stall, 0);
        step();
        mem_ack = 1'b0;
        in_valid = 1'b0;
        chk("post_wb_valid", wb_valid, 1);
        chk("post_wb_data", wb_data, 32'h1357_9BDF);
        chk("post_wb_d", wb_D, 10);
        chk("post_mem_err", mem_err, 0);
        chk("post_mem_req_drop", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage4_mem.md
# stage4_mem

Memory-access pipeline stage: the consumer of the execute stage's registered outputs (ALU result, destination register, 8-bit address, write-enable/source/read/write/jump controls). It performs loads and stores against an external data memory over a req/ack handshake with variable latency. It stalls the execute stage while an access is outstanding and aborts on timeout. It presents a registered writeback bundle and jump request to the writeback stage.

## Interface
- MEM_TIMEOUT, 16: max BUSY cycles without mem_ack before abort (legal range 2..255)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute-stage bundle valid this cycle
- ALU_Result  in  32  ALU result; store data and non-load writeback value
- D  in  4  destination register index
- address  in  8  data-memory address / jump target
- RegWrite, RegInsrc, DataRead, DataWrite, JumpSrc  in  1 each  control bits from execute stage
- stall  out  1  combinational; upstream holds its bundle while high
- mem_req  out  1  registered access request
- mem_we  out  1  1 = store, 0 = load; valid with mem_req
- mem_addr  out  8  access address; valid with mem_req
- mem_wdata  out  32  store data; valid with mem_req
- mem_ack  in  1  access complete this cycle
- mem_rdata  in  32  load data, sampled when mem_ack=1
- wb_valid, wb_RegWrite  out  1 each  writeback bundle valid / register write enable
- wb_D  out  4  destination index
- wb_data  out  32  writeback value
- jump_taken  out  1  jump request to PC logic
- jump_addr  out  8  jump target
- mem_err  out  1  sticky timeout flag

## Operation
- Memory op = in_valid & (DataRead | DataWrite). DataWrite has priority: if both bits are set, the access is a store and the read is ignored.
- FSM states are IDLE and BUSY.
- IDLE, no memory op:
  - Next edge: wb_valid=in_valid, wb_D=D, wb_data=ALU_Result, wb_RegWrite=in_valid&RegWrite.
  - Same edge: jump_taken=in_valid&JumpSrc, jump_addr=address.
- IDLE, memory op:
  - stall=1.
  - Next edge: latch the bundle internally, mem_req=1, mem_we=DataWrite, mem_addr=address, mem_wdata=ALU_Result, clear the timeout counter, go to BUSY, wb_valid=0, jump_taken=0.
- BUSY:
  - Inputs are ignored. mem_req and the access fields are held stable.
  - stall=1 except in a cycle with mem_ack=1.
  - On mem_ack: the next edge drives mem_req=0, issues the writeback from the latched bundle, and returns to IDLE.
  - Writeback value: wb_data = RegInsrc & load ? mem_rdata : latched ALU_Result. jump_taken = latched JumpSrc.
- Timeout:
  - The counter increments every BUSY cycle without ack.
  - When the count reaches MEM_TIMEOUT-1 with no ack, the next edge drives mem_req=0, sets mem_err=1 (sticky until reset), and returns to IDLE.
  - The aborted instruction writes back with wb_valid=1, wb_RegWrite=0, jump_taken=0.
  - stall drops in that final cycle.
- mem_ack coinciding with the timeout terminal count: the ack wins and there is no error.
- mem_ack while in IDLE is ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_RegWrite, wb_D, wb_data, jump_taken, jump_addr, mem_err all 0. Counter 0.
- Non-memory latency: 1 cycle, input to wb outputs.
- Memory latency: bundle presented in cycle N → mem_req high from N+1 → ack in cycle N+k (k≥1) → wb outputs in N+k+1.
- The earliest ack in cycle N+1 gives 2-cycle total latency.
- stall is high through cycles N..N+k-1 and low in N+k, so upstream advances on the ack edge.
- Back-to-back memory ops: the second op is seen in IDLE at N+k+1 and issues its request at N+k+2, so there is one idle request cycle between accesses.
- Reset asserted mid-access drops mem_req immediately. The external memory must tolerate an abandoned request.

## Structure
- Package stage4_mem_pkg holds:
  - state enum {IDLE, BUSY}
  - widths: DATA_W=32, ADDR_W=8, REG_W=4
  - the writeback bundle struct (valid, RegWrite, D, data)
- Sub-module mem_timeout_ctr: clear/enable inputs, terminal-count output, parameterised by MEM_TIMEOUT.
- The FSM and output registers stay in stage4_mem.

## Test plan
- Non-memory op: ALU_Result=0x1234_5678, D=3, RegWrite=1 → next cycle wb_valid=1, wb_D=3, wb_data=0x12345678, stall never high.
- Load with 3-cycle memory: address=0x2A, DataRead=1, RegInsrc=1, mem_rdata=0xDEAD_BEEF with ack on the 3rd request cycle → mem_req high 3 cycles with mem_we=0, mem_addr=0x2A; stall high 3 cycles; wb_data=0xDEADBEEF one cycle after ack.
- Store with both DataRead and DataWrite set: ALU_Result=0xA5A5_0000 → mem_we=1, mem_wdata=0xA5A50000; wb_data=0xA5A50000.
- Timeout, MEM_TIMEOUT=4, no ack → mem_req high exactly 4 cycles; then mem_err=1, wb_valid=1 with wb_RegWrite=0. mem_err stays 1 over later ops.
- Ack in the terminal-count cycle → normal writeback, mem_err stays 0.
- rst_n low during BUSY → mem_req, stall and all outputs go 0 without a clock edge. The first op after release behaves as from reset.
